// File: rtl/ecliptic_fcmp_ctrl.sv
// Issue/collect controller for the single-precision compare unit (FLE/FLT/FEQ/FMIN/FMAX).
// Decodes funct7/funct3, tracks one in-flight request and queues results in order for writeback.
module ecliptic_fcmp_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  in_funct7,
   input  logic [2:0]  in_funct3,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_src1,
   input  logic [31:0] in_src2,
   output logic        cmp_req,
   output logic [2:0]  cmp_op,
   output logic [31:0] cmp_src1,
   output logic [31:0] cmp_src2,
   input  logic [31:0] cmp_res,
   input  logic        cmp_invalid,
   input  logic        cmp_ack,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_res,
   output logic [4:0]  out_rd,
   output logic        out_nv,
   output logic        out_illegal,
   input  logic        fflags_clear,
   output logic        fflags_nv,
   output logic        spurious_ack
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

   logic          run_reg;
   logic          inflight_reg;
   logic [4:0]    tag_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          nv_sticky_reg;
   logic          spurious_reg;

   logic [31:0]   res_mem [DEPTH];
   logic [4:0]    rd_mem  [DEPTH];
   logic          nv_mem  [DEPTH];
   logic          ill_mem [DEPTH];

   logic [2:0]    dec_op;
   logic          dec_legal;
   logic [CW:0]   occ;
   logic          accept, legal_acc, ill_acc, ack_push, push, pop;
   logic [31:0]   push_res;
   logic [4:0]    push_rd;
   logic          push_nv;

   always_comb begin
      dec_op    = 3'b000;
      dec_legal = 1'b0;
      if (in_funct7 == 7'h50) begin
         case (in_funct3)
            3'b000:  begin dec_op = 3'b000; dec_legal = 1'b1; end
            3'b001:  begin dec_op = 3'b001; dec_legal = 1'b1; end
            3'b010:  begin dec_op = 3'b010; dec_legal = 1'b1; end
            default: begin dec_op = 3'b000; dec_legal = 1'b0; end
         endcase
      end else if (in_funct7 == 7'h14) begin
         case (in_funct3)
            3'b000:  begin dec_op = 3'b100; dec_legal = 1'b1; end
            3'b001:  begin dec_op = 3'b101; dec_legal = 1'b1; end
            default: begin dec_op = 3'b000; dec_legal = 1'b0; end
         endcase
      end
   end

   // The in-flight slot counts against capacity so its ack can always be pushed.
   assign occ      = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
   assign in_ready = run_reg && (occ < DEPTH_W) && !(!dec_legal && inflight_reg);

   assign accept    = in_valid && in_ready;
   assign legal_acc = accept && dec_legal;
   assign ill_acc   = accept && !dec_legal;
   assign ack_push  = cmp_ack && inflight_reg;
   assign push      = ack_push || ill_acc;
   assign pop       = out_valid && out_ready;

   assign push_res = ack_push ? cmp_res : 32'd0;
   assign push_rd  = ack_push ? tag_reg : in_rd;
   assign push_nv  = ack_push && cmp_invalid;

   assign cmp_req  = legal_acc;
   assign cmp_op   = dec_op;
   assign cmp_src1 = in_src1;
   assign cmp_src2 = in_src2;

   // Head fields are forced to zero while empty so the outputs read clean after reset.
   assign out_valid   = (count_reg != '0);
   assign out_res     = out_valid ? res_mem[rd_ptr_reg] : 32'd0;
   assign out_rd      = out_valid ? rd_mem[rd_ptr_reg]  : 5'd0;
   assign out_nv      = out_valid && nv_mem[rd_ptr_reg];
   assign out_illegal = out_valid && ill_mem[rd_ptr_reg];

   assign fflags_nv    = nv_sticky_reg;
   assign spurious_ack = spurious_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         res_mem[wr_ptr_reg] <= push_res;
         rd_mem[wr_ptr_reg]  <= push_rd;
         nv_mem[wr_ptr_reg]  <= push_nv;
         ill_mem[wr_ptr_reg] <= !ack_push;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         run_reg       <= 1'b0;
         inflight_reg  <= 1'b0;
         tag_reg       <= 5'd0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         nv_sticky_reg <= 1'b0;
         spurious_reg  <= 1'b0;
      end else begin
         run_reg <= 1'b1;
         if (legal_acc) begin
            inflight_reg <= 1'b1;
            tag_reg      <= in_rd;
         end else if (cmp_ack) begin
            inflight_reg <= 1'b0;
         end
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
         // Clear takes effect first so a same-cycle NV pop still leaves the flag set.
         nv_sticky_reg <= (nv_sticky_reg && !fflags_clear) || (pop && nv_mem[rd_ptr_reg]);
         if (cmp_ack && !inflight_reg) spurious_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ecliptic_fcmp_ctrl.sv
// Directed bench for ecliptic_fcmp_ctrl: table of single-op vectors plus hand-written
// sequences for backpressure, ordering around illegal ops, streaming and reset.
module tb_ecliptic_fcmp_ctrl;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_funct7 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [4:0]  in_rd = '0;
   logic [31:0] in_src1 = '0, in_src2 = '0;
   logic        cmp_req;
   logic [2:0]  cmp_op;
   logic [31:0] cmp_src1, cmp_src2;
   logic [31:0] cmp_res;
   logic        cmp_invalid, cmp_ack;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_res;
   logic [4:0]  out_rd;
   logic        out_nv, out_illegal;
   logic        fflags_clear = 1'b0;
   logic        fflags_nv, spurious_ack;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ecliptic_fcmp_ctrl #(.DEPTH(4)) dut (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_funct7(in_funct7), .in_funct3(in_funct3), .in_rd(in_rd),
      .in_src1(in_src1), .in_src2(in_src2),
      .cmp_req(cmp_req), .cmp_op(cmp_op), .cmp_src1(cmp_src1), .cmp_src2(cmp_src2),
      .cmp_res(cmp_res), .cmp_invalid(cmp_invalid), .cmp_ack(cmp_ack),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_rd(out_rd), .out_nv(out_nv), .out_illegal(out_illegal),
      .fflags_clear(fflags_clear), .fflags_nv(fflags_nv), .spurious_ack(spurious_ack)
   );

   // Compare-unit model: answers one cycle after a request, shares the reset.
   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
   endfunction

   function automatic logic [31:0] unit_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic nan;
      nan = is_nan(a) || is_nan(b);
      case (op)
         3'b000:  return {31'd0, !nan && ($signed(a) <= $signed(b))};
         3'b001:  return {31'd0, !nan && ($signed(a) <  $signed(b))};
         3'b010:  return {31'd0, !nan && (a == b)};
         3'b100:  return ($signed(a) < $signed(b)) ? a : b;
         3'b101:  return ($signed(a) > $signed(b)) ? a : b;
         default: return 32'd0;
      endcase
   endfunction

   logic        ack_pend = 1'b0;
   logic [31:0] pend_res = '0;
   logic        pend_nv = 1'b0;
   logic        inject_ack = 1'b0;

   always @(posedge clk) begin
      ack_pend <= cmp_req && nrst;
      pend_res <= unit_res(cmp_op, cmp_src1, cmp_src2);
      pend_nv  <= is_nan(cmp_src1) || is_nan(cmp_src2);
   end

   assign cmp_ack     = ack_pend || inject_ack;
   assign cmp_res     = pend_res;
   assign cmp_invalid = pend_nv;

   typedef struct {
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] s1;
      logic [31:0] s2;
      logic        legal;
      logic [2:0]  op;
      logic [31:0] res;
      logic        nv;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] s1, input logic [31:0] s2);
      in_valid  = 1'b1;
      in_funct7 = f7;
      in_funct3 = f3;
      in_rd     = rd;
      in_src1   = s1;
      in_src2   = s2;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, next_rd, exp_rd, ni, no, first_c;
      logic [31:0] exp_min;

      vecs[0] = '{7'h50, 3'd1, 5'd5,  32'h3f800000, 32'h40000000, 1'b1, 3'b001, 32'd1,        1'b0};
      vecs[1] = '{7'h50, 3'd0, 5'd7,  32'h7fc00000, 32'h3f800000, 1'b1, 3'b000, 32'd0,        1'b1};
      vecs[2] = '{7'h50, 3'd2, 5'd10, 32'h40400000, 32'h40400000, 1'b1, 3'b010, 32'd1,        1'b0};
      vecs[3] = '{7'h14, 3'd0, 5'd11, 32'h40400000, 32'h3f800000, 1'b1, 3'b100, 32'h3f800000, 1'b0};
      vecs[4] = '{7'h14, 3'd1, 5'd12, 32'h40400000, 32'h3f800000, 1'b1, 3'b101, 32'h40400000, 1'b0};
      vecs[5] = '{7'h50, 3'd3, 5'd9,  32'h11111111, 32'h22222222, 1'b0, 3'b000, 32'd0,        1'b0};
      vecs[6] = '{7'h14, 3'd2, 5'd13, 32'h3f800000, 32'h3f800000, 1'b0, 3'b000, 32'd0,        1'b0};
      vecs[7] = '{7'h51, 3'd0, 5'd14, 32'h3f800000, 32'h40000000, 1'b0, 3'b000, 32'd0,        1'b0};
      vecs[8] = '{7'h50, 3'd1, 5'd3,  32'h40000000, 32'h3f800000, 1'b1, 3'b001, 32'd0,        1'b0};

      // Reset state
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_cmp_req", 32'(cmp_req), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_res", out_res, 32'd0);
      check("rst_out_rd", 32'(out_rd), 32'd0);
      check("rst_out_nv", 32'(out_nv), 32'd0);
      check("rst_out_illegal", 32'(out_illegal), 32'd0);
      check("rst_fflags_nv", 32'(fflags_nv), 32'd0);
      check("rst_spurious", 32'(spurious_ack), 32'd0);
      nrst = 1'b1;
      tick();
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Single-op vectors
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         offer(vecs[i].f7, vecs[i].f3, vecs[i].rd, vecs[i].s1, vecs[i].s2);
         #1;
         check("vec_in_ready", 32'(in_ready), 32'd1);
         check("vec_cmp_req", 32'(cmp_req), 32'(vecs[i].legal));
         if (vecs[i].legal) begin
            check("vec_cmp_op", 32'(cmp_op), 32'(vecs[i].op));
            check("vec_cmp_src1", cmp_src1, vecs[i].s1);
         end
         tick();
         idle();
         if (vecs[i].legal) begin
            check("vec_early_valid", 32'(out_valid), 32'd0);
            tick();
         end
         check("vec_out_valid", 32'(out_valid), 32'd1);
         check("vec_out_res", out_res, vecs[i].res);
         check("vec_out_rd", 32'(out_rd), 32'(vecs[i].rd));
         check("vec_out_nv", 32'(out_nv), 32'(vecs[i].nv));
         check("vec_out_illegal", 32'(out_illegal), 32'(!vecs[i].legal));
         $display("vec %0d: f7=%02h f3=%0d rd=%0d res=%08h nv=%0d illegal=%0d",
                  i, vecs[i].f7, vecs[i].f3, out_rd, out_res, out_nv, out_illegal);
         tick();
         check("vec_popped", 32'(out_valid), 32'd0);
         check("vec_fflags_nv", 32'(fflags_nv), 32'(vecs[i].nv));
         fflags_clear = 1'b1;
         tick();
         fflags_clear = 1'b0;
         check("vec_fflags_cleared", 32'(fflags_nv), 32'd0);
      end

      // Sticky NV: clear in the same cycle as another NV pop keeps the flag set
      out_ready = 1'b0;
      offer(7'h50, 3'd0, 5'd1, 32'h7fc00000, 32'h3f800000);
      tick();
      offer(7'h50, 3'd0, 5'd2, 32'h7fc00000, 32'h3f800000);
      tick();
      idle();
      tick();
      check("nv_head_rd", 32'(out_rd), 32'd1);
      check("nv_head_nv", 32'(out_nv), 32'd1);
      out_ready = 1'b1;
      tick();
      check("nv_set_after_pop", 32'(fflags_nv), 32'd1);
      check("nv_second_rd", 32'(out_rd), 32'd2);
      fflags_clear = 1'b1;
      tick();
      check("nv_clear_and_set", 32'(fflags_nv), 32'd1);
      check("nv_drained", 32'(out_valid), 32'd0);
      tick();
      fflags_clear = 1'b0;
      check("nv_clear_only", 32'(fflags_nv), 32'd0);
      $display("seq nv: clear+pop kept flag, clear alone dropped it");

      // Illegal op held behind an in-flight FEQ
      offer(7'h50, 3'd2, 5'd20, 32'd5, 32'd5);
      #1;
      check("ord_feq_req", 32'(cmp_req), 32'd1);
      tick();
      offer(7'h50, 3'd3, 5'd9, 32'd0, 32'd0);
      #1;
      check("ord_ill_held", 32'(in_ready), 32'd0);
      check("ord_ill_no_req", 32'(cmp_req), 32'd0);
      tick();
      check("ord_ill_ready", 32'(in_ready), 32'd1);
      check("ord_ill_no_req2", 32'(cmp_req), 32'd0);
      check("ord_feq_valid", 32'(out_valid), 32'd1);
      check("ord_feq_rd", 32'(out_rd), 32'd20);
      check("ord_feq_res", out_res, 32'd1);
      check("ord_feq_illegal", 32'(out_illegal), 32'd0);
      tick();
      idle();
      check("ord_ill_valid", 32'(out_valid), 32'd1);
      check("ord_ill_rd", 32'(out_rd), 32'd9);
      check("ord_ill_res", out_res, 32'd0);
      check("ord_ill_flag", 32'(out_illegal), 32'd1);
      tick();
      check("ord_empty", 32'(out_valid), 32'd0);
      $display("seq order: FEQ rd20 then illegal rd9");

      // Backpressure: 6 FMAX offers against a stalled writeback
      out_ready = 1'b0;
      next_rd = 1;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         if (next_rd <= 6) offer(7'h14, 3'd1, 5'(next_rd), 32'(next_rd), 32'd3);
         else idle();
         #1;
         if (in_valid && in_ready) begin
            acc++;
            next_rd++;
         end
         tick();
      end
      check("bp_accepted", 32'(acc), 32'd4);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      exp_rd = 1;
      for (int c = 0; c < 30; c++) begin
         if (out_valid) begin
            check("bp_out_rd", 32'(out_rd), 32'(exp_rd));
            check("bp_out_res", out_res, (exp_rd > 3) ? 32'(exp_rd) : 32'd3);
            $display("bp out: rd=%0d res=%0d", out_rd, out_res);
            exp_rd++;
         end
         if (next_rd <= 6) offer(7'h14, 3'd1, 5'(next_rd), 32'(next_rd), 32'd3);
         else idle();
         #1;
         if (in_valid && in_ready) next_rd++;
         tick();
      end
      idle();
      check("bp_all_out", 32'(exp_rd), 32'd7);
      check("bp_all_in", 32'(next_rd), 32'd7);

      // Streaming 16 FMIN ops at full rate
      ni = 0;
      no = 0;
      first_c = -1;
      for (int c = 0; c < 24; c++) begin
         if (out_valid) begin
            if (first_c < 0) first_c = c;
            exp_min = (no * 3 < 20) ? 32'(no * 3) : 32'd20;
            check("st_out_rd", 32'(out_rd), 32'(no));
            check("st_out_res", out_res, exp_min);
            no++;
         end
         if (ni < 16) offer(7'h14, 3'd0, 5'(ni), 32'(ni * 3), 32'd20);
         else idle();
         #1;
         if (ni < 16) begin
            check("st_in_ready", 32'(in_ready), 32'd1);
            if (in_ready) ni++;
         end
         tick();
      end
      idle();
      check("st_issued", 32'(ni), 32'd16);
      check("st_received", 32'(no), 32'd16);
      check("st_latency", 32'(first_c), 32'd2);
      $display("seq stream: issued %0d, received %0d, first result at cycle %0d", ni, no, first_c);

      // Reset with one in flight and two queued
      out_ready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         offer(7'h50, 3'd1, 5'(k), 32'd1, 32'd2);
         tick();
      end
      idle();
      check("mr_queued", 32'(out_valid), 32'd1);
      nrst = 1'b0;
      tick();
      check("mr_out_valid", 32'(out_valid), 32'd0);
      check("mr_in_ready", 32'(in_ready), 32'd0);
      check("mr_out_res", out_res, 32'd0);
      check("mr_out_rd", 32'(out_rd), 32'd0);
      check("mr_cmp_req", 32'(cmp_req), 32'd0);
      nrst = 1'b1;
      tick();
      check("mr_in_ready_after", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         if (out_valid) acc++;
         tick();
      end
      check("mr_nothing_emitted", 32'(acc), 32'd0);
      check("mr_spurious", 32'(spurious_ack), 32'd0);
      inject_ack = 1'b1;
      tick();
      inject_ack = 1'b0;
      check("sp_flag", 32'(spurious_ack), 32'd1);
      check("sp_fifo_empty", 32'(out_valid), 32'd0);
      tick();
      check("sp_fifo_still_empty", 32'(out_valid), 32'd0);
      check("sp_sticky", 32'(spurious_ack), 32'd1);
      $display("seq reset/spurious: spurious_ack=%0d out_valid=%0d", spurious_ack, out_valid);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ecliptic_fcmp_ctrl.md
# ecliptic_fcmp_ctrl

Issue/collect controller in front of the single-precision comparison unit (FLE/FLT/FEQ/FMIN/FMAX). It accepts decoded F-extension instruction fields over a valid/ready handshake and translates funct7/funct3 into the unit's op code. It issues the request, captures the unit's one-cycle result pulse into an in-order output FIFO, and presents result, destination register and NV exception to writeback. It also keeps the sticky NV bit of fflags for these ops.

## Interface
- DEPTH, 4, output FIFO entries (≥3; power of two)
- clk  in  1  clock
- nrst  in  1  synchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid & in_ready
- in_funct7  in  7  instruction funct7
- in_funct3  in  3  instruction funct3 (rm field)
- in_rd  in  5  destination register
- in_src1, in_src2  in  32  operands (rs1, rs2 values)
- cmp_req  out  1  request to comparison unit
- cmp_op  out  3  LE=000, LT=001, EQ=010, MIN=100, MAX=101
- cmp_src1, cmp_src2  out  32  operands to comparison unit
- cmp_res  in  32  unit result, valid with cmp_ack
- cmp_invalid  in  1  unit NV flag, valid with cmp_ack
- cmp_ack  in  1  one-cycle result pulse, one cycle after cmp_req
- out_valid  out  1  FIFO head valid
- out_ready  in  1  writeback consumes head
- out_res  out  32  head result
- out_rd  out  5  head destination
- out_nv  out  1  head invalid-operation flag
- out_illegal  out  1  head is an undecodable instruction
- fflags_clear  in  1  clear sticky NV
- fflags_nv  out  1  sticky NV
- spurious_ack  out  1  sticky: cmp_ack seen with nothing in flight

## Operation
- Decode: funct7=0x50 with funct3 000/001/010 → LE/LT/EQ; funct7=0x14 with funct3 000/001 → MIN/MAX. Any other combination is illegal.
- Legal accept: cmp_req=1 in the accept cycle (combinational from handshake). cmp_src1/2 = in_src1/2 and cmp_op = decoded op. in_rd goes into an inflight tag register; inflight flag is set.
- cmp_req=0 whenever there is no legal accept. cmp_op/cmp_src pass through unconditionally.
- cmp_ack with inflight=1: push {cmp_res, tag rd, cmp_invalid, illegal=0}; inflight clears unless a new legal accept occurs in the same cycle.
- cmp_ack with inflight=0: dropped, spurious_ack set (cleared only by reset).
- Illegal accept: pushes {0, in_rd, nv=0, illegal=1} directly. It is only accepted when inflight=0, which preserves order and avoids a double push.
- in_ready = (count + inflight) < DEPTH, and additionally not (illegal & inflight). in_ready does not depend on out_ready (no pass-through).
- FIFO: circular, pointers wrap modulo DEPTH. Push and pop in the same cycle leave count unchanged. Push is never attempted when full (guaranteed by the in_ready rule).
- Pop when out_valid & out_ready; out_* show the head entry.
- fflags_nv: set when a pop has out_nv=1; cleared by fflags_clear. If both happen in the same cycle, the result is 1 (clear applies first, then set).

## Timing
- Reset values: in_ready=0 during reset, 1 the cycle after. cmp_req=0, out_valid=0, out_res=0, out_rd=0, out_nv=0, out_illegal=0, fflags_nv=0, spurious_ack=0. Inflight, count and pointers are 0.
- Legal op accepted in cycle N: cmp_ack in N+1, push at end of N+1, out_valid in N+2. Latency is 2.
- Illegal op accepted in cycle N: out_valid in N+1.
- Throughput is one op per cycle while out_ready=1.
- out_valid stays high and out_* stay stable until popped.
- Reset mid-operation: inflight and FIFO are discarded. An ack in the first cycle after reset release is counted as spurious only if cmp_ack=1, which cannot occur because the unit shares the reset.

## Test plan
- FLT.S (funct7 0x50, funct3 001, rd 5), src1=0x3f800000, src2=0x40000000, unit model returns 1 → cmp_req with cmp_op=001 in N, out_valid in N+2 with out_res=1, out_rd=5, out_nv=0.
- FLE.S, model returns cmp_invalid=1, res 0 → out_nv=1. fflags_nv=1 the cycle after the pop; fflags_clear then drops it to 0. Clear in the same cycle as another nv pop → stays 1.
- out_ready=0, 6 back-to-back FMAX.S offers with rd 1..6 → exactly 4 accepted, in_ready=0. Then out_ready=1 → rd 1,2,3,4 drained in order, then 5 and 6 accepted.
- Illegal funct7 0x50, funct3 011, rd 9, offered the cycle after a legal FEQ → held (in_ready=0) one cycle, no cmp_req. Output order: FEQ, then {res 0, rd 9, illegal 1}.
- Streaming 16 FMIN.S ops with out_ready=1 → one accept per cycle, results in order, no stall.
- nrst asserted with 1 inflight and 2 queued → all outputs at reset values, nothing emitted after release. Injected cmp_ack with no request → spurious_ack=1, FIFO unchanged.
